// File: rtl/fir_pkg.sv
//------------------------------------------------------------------------------
// fir_pkg
//   Types and constants shared by the FIR filter and its coefficient loader.
//   Holds the coefficient-transmitter state enum, the tap-to-coefficient
//   count helper and the default word width / tap count used by the filter.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fir_pkg;

  // Default filter geometry, kept in one place so filter and loader agree.
  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_NTAPS      = 9;

  // Coefficient transmitter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } coeff_tx_state_e;

  // A symmetric filter with nTaps (odd) taps stores only half the
  // coefficients plus the centre tap.
  function automatic int ncoeffs(input int nTaps);
    return (nTaps + 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coeff_bank.sv
//------------------------------------------------------------------------------
// fir_coeff_bank
//   Host-writable coefficient register file. Each word is written when
//   i_wr_en is high and i_wr_addr selects it; addresses at or beyond
//   NCoeffs match no entry and are dropped. All words are presented at
//   once on o_snap, word k at bits [k*DataWidth +: DataWidth], so the
//   highest-index word sits at the MSB end.
//   Ports:
//     clk, rstN          clock, synchronous active-low reset (clears bank)
//     i_wr_en            write strobe
//     i_wr_addr          word index
//     i_wr_data          word value
//     o_snap             flattened NCoeffs*DataWidth view of the bank
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_coeff_bank #(
  parameter int DataWidth = 12,
  parameter int NCoeffs   = 5,
  parameter int AddrWidth = 3
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic                           i_wr_en,
  input  logic [AddrWidth-1:0]           i_wr_addr,
  input  logic [DataWidth-1:0]           i_wr_data,
  output logic [NCoeffs*DataWidth-1:0]   o_snap
);

  for (genvar i = 0; i < NCoeffs; i++) begin : g_entry
    localparam logic [AddrWidth-1:0] c_idx = AddrWidth'(i);
    logic [DataWidth-1:0] r_word;

    always_ff @(posedge clk) begin
      if (!rstN) begin
        r_word <= '0;
      end else if (i_wr_en && (i_wr_addr == c_idx)) begin
        r_word <= i_wr_data;
      end
    end

    assign o_snap[i*DataWidth +: DataWidth] = r_word;
  end

endmodule

`default_nettype wire

// File: rtl/fir_coeff_tx.sv
//------------------------------------------------------------------------------
// fir_coeff_tx
//   Bit-serial coefficient transmitter for the FIR filter load port.
//   On load_req the coefficient bank is snapshotted (once the filter is idle)
//   and shifted out MSB-first, highest word first, one bit per cycle with
//   coeff_load_in high for the whole transfer. Sample starts are only passed
//   to the filter while idle so a load never overlaps a MAC run.
//   Ports:
//     clk, rstN                 clock, synchronous active-low reset
//     wr_en/wr_addr/wr_data     host bank write
//     load_req                  request a transfer (level, sampled per cycle)
//     busy, load_done           transfer status / completion pulse
//     start_in, fir_start       host start request / start to filter
//     start_ok                  high while starts are accepted (IDLE)
//     fir_done                  filter completion pulse
//     coeff_load_in, coeff_in   serial coefficient stream to the filter
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_coeff_tx
  import fir_pkg::*;
#(
  parameter  int DataWidth = DEF_DATA_WIDTH,
  parameter  int NTaps     = DEF_NTAPS,
  localparam int NCoeffs   = ncoeffs(NTaps),
  localparam int AddrWidth = (NCoeffs > 1) ? $clog2(NCoeffs) : 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 load_req,
  output logic                 busy,
  output logic                 load_done,
  input  logic                 start_in,
  output logic                 fir_start,
  output logic                 start_ok,
  input  logic                 fir_done,
  output logic                 coeff_load_in,
  output logic                 coeff_in
);

  localparam int TotalBits = NCoeffs * DataWidth;
  localparam int CntWidth  = $clog2(TotalBits);
  localparam logic [CntWidth-1:0] c_last_cnt = CntWidth'(TotalBits - 1);

  // The filter's symmetric coefficient folding requires an odd tap count.
  if (NTaps % 2 == 0) begin : g_ntaps_even
    $error("fir_coeff_tx: NTaps must be odd");
  end

  coeff_tx_state_e         r_state;
  logic                    r_fir_busy;
  logic [TotalBits-1:0]    r_shift;
  logic [CntWidth-1:0]     r_cnt;
  logic                    r_coeff_load;
  logic                    r_coeff_bit;
  logic                    r_load_done;

  logic [TotalBits-1:0]    w_snap;
  logic                    w_start_ok;
  logic                    w_fir_start;
  logic                    w_busy_clear;
  logic                    w_take_snap;

  fir_coeff_bank #(
    .DataWidth (DataWidth),
    .NCoeffs   (NCoeffs),
    .AddrWidth (AddrWidth)
  ) u_bank (
    .clk       (clk),
    .rstN      (rstN),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_snap    (w_snap)
  );

  assign w_start_ok  = (r_state == IDLE);
  assign w_fir_start = start_in & w_start_ok;

  // fir_start cannot fire outside IDLE, so in WAIT the busy flag is free
  // after this edge whenever it is already clear or fir_done is arriving.
  // Leaving WAIT on that condition sends the first bit on the cycle right
  // after fir_done.
  assign w_busy_clear = !r_fir_busy || fir_done;

  // A start request in the same cycle as load_req takes priority.
  assign w_take_snap = ((r_state == IDLE) && load_req && !start_in && !r_fir_busy) ||
                       ((r_state == WAIT) && w_busy_clear);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state      <= IDLE;
      r_fir_busy   <= 1'b0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_coeff_load <= 1'b0;
      r_coeff_bit  <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;

      // Set wins over clear when both happen together.
      if (w_fir_start) begin
        r_fir_busy <= 1'b1;
      end else if (fir_done) begin
        r_fir_busy <= 1'b0;
      end

      if (w_take_snap) begin
        // The first bit goes out straight from the snapshot; the rest are
        // queued MSB-aligned in the shift register.
        r_state      <= SHIFT;
        r_coeff_load <= 1'b1;
        r_coeff_bit  <= w_snap[TotalBits-1];
        r_shift      <= {w_snap[TotalBits-2:0], 1'b0};
        r_cnt        <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (load_req) begin
              r_state <= WAIT;
            end
          end
          WAIT: begin
            r_state <= WAIT;
          end
          SHIFT: begin
            if (r_cnt == c_last_cnt) begin
              r_state      <= IDLE;
              r_coeff_load <= 1'b0;
              r_coeff_bit  <= 1'b0;
              r_load_done  <= 1'b1;
              r_cnt        <= '0;
            end else begin
              r_cnt       <= r_cnt + 1'b1;
              r_coeff_bit <= r_shift[TotalBits-1];
              r_shift     <= {r_shift[TotalBits-2:0], 1'b0};
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign load_done     = r_load_done;
  assign start_ok      = w_start_ok;
  assign fir_start     = w_fir_start;
  assign coeff_load_in = r_coeff_load;
  assign coeff_in      = r_coeff_bit;

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_tx.sv
//------------------------------------------------------------------------------
// tb_fir_coeff_tx
//   Self-checking bench for fir_coeff_tx. A bank model and a filter-side
//   shift-chain model collect the serial stream; each transfer is compared
//   word-by-word against the bank contents captured at request time.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_coeff_tx;

  localparam int DW = 12;
  localparam int NT = 9;
  localparam int NC = (NT + 1) / 2;
  localparam int AW = 3;
  localparam int TB = NC * DW;

  logic          clk = 1'b0;
  logic          rstN;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          load_req;
  logic          busy;
  logic          load_done;
  logic          start_in;
  logic          fir_start;
  logic          start_ok;
  logic          fir_done;
  logic          coeff_load_in;
  logic          coeff_in;

  fir_coeff_tx #(.DataWidth(DW), .NTaps(NT)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .load_req      (load_req),
    .busy          (busy),
    .load_done     (load_done),
    .start_in      (start_in),
    .fir_start     (fir_start),
    .start_ok      (start_ok),
    .fir_done      (fir_done),
    .coeff_load_in (coeff_load_in),
    .coeff_in      (coeff_in)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Filter-side model: the filter's coefficient shift chain and a count of
  // accepted sample starts.
  int            cyc       = 0;
  int            tot_bits  = 0;
  int            first_cyc = -1;
  int            last_cyc  = -1;
  int            n_samples = 0;
  logic          prev_load = 1'b0;
  logic [TB-1:0] chain     = '0;

  logic [DW-1:0] bank_m [NC];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (coeff_load_in === 1'b1) begin
      if (prev_load !== 1'b1) first_cyc <= cyc;
      last_cyc <= cyc;
      tot_bits <= tot_bits + 1;
      chain    <= {chain[TB-2:0], coeff_in};
    end
    prev_load <= coeff_load_in;
    if (fir_start === 1'b1) n_samples <= n_samples + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bank_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (int'(a) < NC) bank_m[a] = d;
  endtask

  // mode 0: load from idle; mode 1: start, then load_req two cycles later;
  // mode 2: load_req and start_in together. dly = WAIT cycles before fir_done.
  // mid 1: start_in pulse and bank write during SHIFT; mid 2: reset in SHIFT.
  task automatic xfer(input string tag, input int mode, input int dly, input int mid);
    logic [DW-1:0] exp_w [NC];
    int c0, tb0, s0, fd, exp_first;
    bit got;
    for (int i = 0; i < NC; i++) exp_w[i] = bank_m[i];
    tb0 = tot_bits;
    s0  = n_samples;
    got = 1'b0;
    if (mode == 0) begin
      c0 = cyc;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      exp_first = c0 + 1;
    end else begin
      start_in = 1'b1;
      if (mode == 2) load_req = 1'b1;
      #1;
      check({tag, "_fir_start"}, fir_start, 1);
      step();
      start_in = 1'b0;
      load_req = 1'b0;
      if (mode == 1) begin
        step();
        load_req = 1'b1;
        step();
        step();
        load_req = 1'b0;
      end
      check({tag, "_wait_busy"}, busy, 1);
      check({tag, "_wait_start_ok"}, start_ok, 0);
      for (int k = 0; k < dly; k++) begin
        check({tag, "_wait_noload"}, coeff_load_in, 0);
        step();
      end
      fir_done = 1'b1;
      fd = cyc;
      step();
      fir_done = 1'b0;
      exp_first = fd + 1;
    end
    for (int k = 0; k < 200; k++) begin
      if (load_done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (mid == 1 && k == 4) begin
        start_in = 1'b1;
        #1;
        check({tag, "_shift_fir_start"}, fir_start, 0);
        check({tag, "_shift_start_ok"}, start_ok, 0);
      end
      if (mid == 1 && k == 5) start_in = 1'b0;
      if (mid == 1 && k == 9) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 12'h123;
      end
      if (mid == 1 && k == 10) begin
        wr_en = 1'b0;
        bank_m[2] = 12'h123;
      end
      if (mid == 2 && k == 29) begin
        rstN = 1'b0;
        step();
        check({tag, "_rst_load"}, coeff_load_in, 0);
        check({tag, "_rst_bit"}, coeff_in, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_done"}, load_done, 0);
        check({tag, "_rst_start_ok"}, start_ok, 1);
        rstN = 1'b1;
        for (int i = 0; i < NC; i++) bank_m[i] = '0;
        return;
      end
      step();
    end
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_first_bit_cycle"}, first_cyc, exp_first);
    check({tag, "_nbits"}, tot_bits - tb0, TB);
    check({tag, "_contiguous"}, last_cyc - first_cyc + 1, TB);
    check({tag, "_done_cycle"}, cyc, first_cyc + TB);
    check({tag, "_idle_after"}, busy, 0);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("%s_coeff%0d", tag, i), chain[i*DW +: DW], exp_w[i]);
    end
    if (mid == 1) check({tag, "_samples_unchanged"}, n_samples, s0);
  endtask

  initial begin
    int nw, md, dl;
    logic [AW-1:0] a;
    rstN = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_req = 1'b0; start_in = 1'b0; fir_done = 1'b0;
    for (int i = 0; i < NC; i++) bank_m[i] = '0;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_load_done", load_done, 0);
    check("reset_coeff_load", coeff_load_in, 0);
    check("reset_coeff_in", coeff_in, 0);
    check("reset_start_ok", start_ok, 1);
    check("reset_fir_start", fir_start, 0);
    rstN = 1'b1;
    step();

    // Directed bank pattern plus an out-of-range write that must be ignored.
    bank_write(3'd0, 12'h001);
    bank_write(3'd1, 12'h7FF);
    bank_write(3'd2, 12'h800);
    bank_write(3'd3, 12'h555);
    bank_write(3'd4, 12'hAAA);
    bank_write(3'd7, 12'hFFF);
    xfer("directed", 0, 0, 0);
    step();
    xfer("start_then_load", 1, 3, 0);
    step();
    xfer("same_cycle", 2, 4, 0);
    step();
    xfer("shift_disturb", 0, 0, 1);
    step();
    xfer("after_write", 0, 0, 0);
    check("bank2_new", chain[2*DW +: DW], 12'h123);
    step();
    xfer("mid_reset", 0, 0, 2);
    step();
    xfer("after_reset", 0, 0, 0);
    step();

    for (int it = 0; it < 4; it++) begin
      nw = int'($urandom_range(2, 6));
      for (int w = 0; w < nw; w++) begin
        a = AW'($urandom_range(0, 7));
        bank_write(a, DW'($urandom));
      end
      md = int'($urandom_range(0, 2));
      dl = int'($urandom_range(1, 6));
      xfer($sformatf("rand%0d", it), md, dl, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_coeff_tx.md
# fir_coeff_tx

Bit-serial coefficient transmitter driving the FIR filter's coefficient-load port (coeff_load_in / coeff_in). Host software writes coefficient words into a parallel register bank. On request, the block snapshots the bank and shifts all NCoeffs words into the filter in the order the filter's shift chain expects. It also gates sample starts so a coefficient load never overlaps a MAC operation.

## Interface
- DataWidth, 12, coefficient word width; format SFix<1,DataWidth-1>
- NTaps, 9, filter tap count; must be odd
- NCoeffs (localparam), (NTaps+1)/2, number of stored coefficients
- AddrWidth (localparam), $clog2(NCoeffs), bank address width
- clk  in  1  clock
- rstN  in  1  reset; synchronous, active-low
- wr_en  in  1  bank write strobe
- wr_addr  in  AddrWidth  bank index; values >= NCoeffs ignored
- wr_data  in  DataWidth  coefficient word
- load_req  in  1  request a full coefficient transfer (level sampled each cycle)
- busy  out  1  load pending or in progress
- load_done  out  1  one-cycle pulse after the last bit is sent
- start_in  in  1  host sample-start request
- fir_start  out  1  start to filter: start_in & start_ok
- start_ok  out  1  high only in IDLE
- fir_done  in  1  filter done pulse
- coeff_load_in  out  1  to filter; high while bits are valid
- coeff_in  out  1  serial coefficient bit

## Operation
- Bank: NCoeffs x DataWidth registers, zero on reset. A write takes effect at the next edge in any state.
- fir_busy flag: set when fir_start=1, cleared when fir_done=1. If both occur in the same cycle, set wins.
- States (shared enum): IDLE, WAIT, SHIFT.
  - IDLE with load_req and start_in both high: start wins (fir_start=1), go to WAIT.
  - IDLE with load_req and fir_busy=1: go to WAIT.
  - IDLE with load_req and fir_busy=0: snapshot the bank into the NCoeffs*DataWidth shift register, go to SHIFT.
  - WAIT: on fir_busy=0, snapshot the bank, go to SHIFT. Further load_req pulses in WAIT or SHIFT are absorbed.
  - SHIFT: send one bit per cycle for NCoeffs*DataWidth cycles, then return to IDLE and pulse load_done.
- Bit order: bank[NCoeffs-1] first, then downward to bank[0]. Each word MSB first, so the first bit sent lands in filter word NCoeffs-1, bit DataWidth-1.
- coeff_load_in stays high for exactly NCoeffs*DataWidth consecutive cycles per transfer, with no gaps.
- Bank writes during SHIFT do not alter the in-flight stream; they apply to the next transfer.
- start_in outside IDLE is dropped, not queued. The host observes start_ok.
- busy = (state != IDLE).

## Timing
- Reset values: busy=0, load_done=0, coeff_load_in=0, coeff_in=0, start_ok=1, fir_start=0. State is IDLE, fir_busy=0, bit counter=0.
- All outputs are registered except fir_start and start_ok, which are combinational from the state register and start_in.
- load_req at edge t in IDLE, filter idle: coeff_load_in=1 for cycles t+1 .. t+NCoeffs*DataWidth. load_done=1 at cycle t+NCoeffs*DataWidth+1, when busy returns to 0.
- Default parameters: 60-bit transfer, load_done 61 cycles after the request.
- Bit counter width is $clog2(NCoeffs*DataWidth) and counts 0 .. NCoeffs*DataWidth-1. Terminal count triggers the exit; there is no wrap inside a transfer.
- Reset mid-SHIFT: coeff_load_in=0 after the reset edge, the partial stream is abandoned, and the bank is cleared.
- The first bit after WAIT leaves on the cycle after the cycle in which fir_done is observed.

## Structure
- fir_pkg holds:
  - the state enum coeff_tx_state_e {IDLE, WAIT, SHIFT};
  - a function ncoeffs(nTaps);
  - default DataWidth/NTaps constants shared with the filter.
- One sub-module: fir_coeff_bank, the addressed register file with a flattened NCoeffs*DataWidth snapshot output. The FSM, counter and serializer live in fir_coeff_tx.
- An odd-NTaps check uses the same generate-failure idiom as the filter.

## Test plan
- Write bank = {0x001,0x7FF,0x800,0x555,0xAAA} (index 0..4), pulse load_req, with the filter instantiated. Required response:
  - exactly 60 coeff_load_in cycles;
  - filter coeffs[i] equals bank[i] for all i;
  - load_done one cycle after the last bit.
- Assert start_in (fir_start=1), then load_req two cycles later. Required response: state WAIT, coeff_load_in=0 until fir_done, first bit on the following cycle.
- Assert load_req and start_in in the same IDLE cycle. Required response: fir_start=1, transfer deferred until fir_done.
- Pulse start_in during SHIFT. Required response: fir_start=0, start_ok=0, filter sample registers unchanged.
- Write wr_addr=2, wr_data=0x123 in SHIFT cycle 10. Required response: the stream carries the old value; the next transfer carries 0x123. A write to wr_addr=7 changes nothing.
- Drop rstN in SHIFT cycle 30. Required response: all outputs at reset values next cycle, bank reads zero, and a subsequent load sends 60 zero bits.
